// File: rtl/config_bitstream_loader_pkg.sv
// Shared definitions for the configuration bitstream loader.
// Holds the FSM state encoding and the word-count helper used by the
// loader and by any host-side model that needs to size a bitstream.
package config_bitstream_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

  // Number of host words needed to cover the chain: ceil(chain_length / word_width)
  function automatic int unsigned words_needed(input int unsigned chain_length,
                                               input int unsigned word_width);
    return (chain_length + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/config_bitstream_loader.sv
// Host-side driver for the fabric configuration shift chain.
// Clears the chain, then pulls bitstream words over valid/ready and shifts
// them MSB-first into the chain for exactly CHAIN_LENGTH cycles.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle pulse starting a load (honoured in IDLE/DONE)
//   word_in       bitstream word, MSB shifted first
//   word_valid    word_in is valid
//   word_ready    loader accepts word_in this cycle
//   config_data   serial data to the chain
//   config_enable chain shift enable
//   config_nreset active-low chain clear
//   busy          load in progress
//   done          chain fully loaded; held until next start or reset
module config_bitstream_loader
  import config_bitstream_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 1602,
  parameter int unsigned WORD_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BC_W = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned WB_W = $clog2(WORD_WIDTH + 1);

  loader_state_t         state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [BC_W-1:0]       bit_count_q, bit_count_d;
  logic [WB_W-1:0]       word_bit_q, word_bit_d;

  logic word_ready_d, config_data_d, config_enable_d, config_nreset_d;
  logic busy_d, done_d;

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      bit_count_q   <= '0;
      word_bit_q    <= '0;
      word_ready    <= 1'b0;
      config_data   <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      bit_count_q   <= bit_count_d;
      word_bit_q    <= word_bit_d;
      word_ready    <= word_ready_d;
      config_data   <= config_data_d;
      config_enable <= config_enable_d;
      config_nreset <= config_nreset_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_count_d = bit_count_q;
    word_bit_d  = word_bit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        bit_count_d = '0;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        // word_ready is registered high throughout FETCH, so valid alone completes the handshake
        if (word_valid) begin
          word_d     = word_in;
          word_bit_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        word_d      = word_q << 1;
        bit_count_d = bit_count_q + BC_W'(1);
        word_bit_d  = word_bit_q + WB_W'(1);
        // Chain end wins over word end: leftover low bits of the last word are dropped
        if (bit_count_q == BC_W'(CHAIN_LENGTH - 1)) begin
          state_d = ST_DONE;
        end else if (word_bit_q == WB_W'(WORD_WIDTH - 1)) begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered versions of the decode of the upcoming state
    word_ready_d    = (state_d == ST_FETCH);
    config_enable_d = (state_d == ST_SHIFT);
    config_data_d   = (state_d == ST_SHIFT) ? word_d[WORD_WIDTH-1] : 1'b0;
    config_nreset_d = (state_d != ST_CLEAR);
    busy_d          = (state_d == ST_CLEAR) || (state_d == ST_FETCH) || (state_d == ST_SHIFT);
    done_d          = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Self-checking bench for config_bitstream_loader: a small 10/4 instance for
// the directed and randomized scenarios and a default 1602/32 instance for
// the full-size load, each driving a model of the configuration chain.
module tb_config_bitstream_loader;
  import config_bitstream_loader_pkg::*;

  localparam int unsigned LS = 10;
  localparam int unsigned WS = 4;
  localparam int unsigned NS = words_needed(LS, WS);
  localparam int unsigned LB = 1602;
  localparam int unsigned WB = 32;
  localparam int unsigned NB = words_needed(LB, WB);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic          s_start, s_valid, s_ready, s_data, s_en, s_nrst, s_busy, s_done;
  logic [WS-1:0] s_word;
  logic          b_start, b_valid, b_ready, b_data, b_en, b_nrst, b_busy, b_done;
  logic [WB-1:0] b_word;

  int passed = 0;
  int total  = 0;

  config_bitstream_loader #(.CHAIN_LENGTH(LS), .WORD_WIDTH(WS)) dut_small (
    .clock(clock), .reset(reset), .start(s_start), .word_in(s_word),
    .word_valid(s_valid), .word_ready(s_ready), .config_data(s_data),
    .config_enable(s_en), .config_nreset(s_nrst), .busy(s_busy), .done(s_done)
  );

  config_bitstream_loader #(.CHAIN_LENGTH(LB), .WORD_WIDTH(WB)) dut_big (
    .clock(clock), .reset(reset), .start(b_start), .word_in(b_word),
    .word_valid(b_valid), .word_ready(b_ready), .config_data(b_data),
    .config_enable(b_en), .config_nreset(b_nrst), .busy(b_busy), .done(b_done)
  );

  // Configuration shift register models (load targets)
  logic [LS-1:0] chain_s;
  logic          preload_s = 1'b0;
  always @(posedge clock) begin
    if (preload_s)   chain_s <= '1;
    else if (!s_nrst) chain_s <= '0;
    else if (s_en)    chain_s <= {chain_s[LS-2:0], s_data};
  end

  logic [LB-1:0] chain_b;
  always @(posedge clock) begin
    if (!b_nrst)   chain_b <= '0;
    else if (b_en) chain_b <= {chain_b[LB-2:0], b_data};
  end

  // Host bitstreams
  logic [WS-1:0] sw [NS];
  logic [WB-1:0] bw [NB];

  // Reference: concatenate words MSB-first, first stream bit lands at the chain MSB
  function automatic logic [LS-1:0] model_small();
    bit q[$];
    logic [LS-1:0] r;
    for (int i = 0; i < int'(NS); i++)
      for (int b = int'(WS) - 1; b >= 0; b--) q.push_back(sw[i][b]);
    for (int i = 0; i < int'(LS); i++) r[int'(LS) - 1 - i] = q[i];
    return r;
  endfunction

  function automatic logic [LB-1:0] model_big();
    bit q[$];
    logic [LB-1:0] r;
    for (int i = 0; i < int'(NB); i++)
      for (int b = int'(WB) - 1; b >= 0; b--) q.push_back(bw[i][b]);
    for (int i = 0; i < int'(LB); i++) r[int'(LB) - 1 - i] = q[i];
    return r;
  endfunction

  // One full load on the small instance with optional stall and stray start pulses
  task automatic small_load(input string name, input int stall_idx, input int stall_len,
                            input bit inject);
    int lat = 0, ens = 0, acc = 0, stalled = 0, extra = 0, bad_en = 0;
    bit inj_f = 0, inj_s = 0, done_seen = 0;
    int exp_lat;
    logic [LS-1:0] exp_chain;
    exp_lat = 1 + int'(NS) + int'(LS) + ((stall_idx < int'(NS)) ? stall_len : 0);
    exp_chain = model_small();

    @(negedge clock);
    s_start = 1'b1; s_valid = 1'($urandom); s_word = WS'($urandom);
    @(negedge clock);
    s_start = 1'b0;
    total++; if (s_nrst !== 1'b0) $display("FAIL %s clear_nreset: got %b want 0", name, s_nrst); else passed++;
    total++; if (s_done !== 1'b0) $display("FAIL %s clear_done: got %b want 0", name, s_done); else passed++;
    total++; if (s_busy !== 1'b1) $display("FAIL %s clear_busy: got %b want 1", name, s_busy); else passed++;

    for (int c = 0; c < 300 && !done_seen; c++) begin
      s_start = 1'b0;
      if (s_ready === 1'b1) begin
        if (s_en !== 1'b0) bad_en++;
        if (acc == stall_idx && stalled < stall_len) begin
          s_valid = 1'b0; s_word = WS'($urandom); stalled++;
        end else begin
          s_valid = 1'b1;
          s_word  = (acc < int'(NS)) ? sw[acc] : WS'($urandom);
          acc++;
        end
        if (inject && !inj_f) begin s_start = 1'b1; inj_f = 1; end
      end else begin
        s_valid = 1'($urandom); s_word = WS'($urandom);
        if (inject && s_en === 1'b1 && !inj_s) begin s_start = 1'b1; inj_s = 1; end
      end
      if (s_en === 1'b1) ens++;
      @(posedge clock);
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        total++;
        if (chain_s !== '0 || s_nrst !== 1'b1)
          $display("FAIL %s clear_chain: got chain %b nreset %b want 0 / 1", name, chain_s, s_nrst);
        else passed++;
      end else if (s_nrst !== 1'b1) extra++;
      if (s_done === 1'b1) done_seen = 1;
    end
    s_valid = 1'b0; s_start = 1'b0;

    total++; if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); else passed++;
    total++; if (ens != int'(LS)) $display("FAIL %s enable_count: got %0d want %0d", name, ens, LS); else passed++;
    total++; if (acc != int'(NS)) $display("FAIL %s words_consumed: got %0d want %0d", name, acc, NS); else passed++;
    total++; if (chain_s !== exp_chain) $display("FAIL %s chain: got %b want %b", name, chain_s, exp_chain); else passed++;
    total++; if (extra != 0) $display("FAIL %s extra_clear: got %0d want 0", name, extra); else passed++;
    total++; if (bad_en != 0) $display("FAIL %s enable_in_fetch: got %0d want 0", name, bad_en); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({s_ready, s_data, s_en, s_nrst, s_busy, s_done} !== 6'b000100)
      $display("FAIL reset_small: got %b want 000100", {s_ready, s_data, s_en, s_nrst, s_busy, s_done});
    else passed++;
    total++;
    if ({b_ready, b_data, b_en, b_nrst, b_busy, b_done} !== 6'b000100)
      $display("FAIL reset_big: got %b want 000100", {b_ready, b_data, b_en, b_nrst, b_busy, b_done});
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sw[0] = 4'hA; sw[1] = 4'h5; sw[2] = 4'hC;
    small_load("basic", int'(NS), 0, 1'b0);
    total++;
    if (chain_s !== 10'b1010010111) $display("FAIL basic_known_chain: got %b want 1010010111", chain_s);
    else passed++;
  endtask

  task automatic test_stall();
    sw[0] = 4'hA; sw[1] = 4'h5; sw[2] = 4'hC;
    small_load("stall", 2, 5, 1'b0);
  endtask

  task automatic test_clear();
    @(negedge clock); preload_s = 1'b1;
    @(negedge clock); preload_s = 1'b0;
    total++; if (chain_s !== '1) $display("FAIL preload: got %b want all ones", chain_s); else passed++;
    for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
    small_load("clear", int'(NS), 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    @(negedge clock); s_start = 1'b1;
    @(negedge clock); s_start = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 100 && cnt < 6; c++) begin
      s_word = WS'($urandom);
      if (s_en === 1'b1) cnt++;
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    total++; if (cnt != 6) $display("FAIL mid_reset_reach: got %0d bits want 6", cnt); else passed++;
    total++;
    if ({s_ready, s_en, s_done, s_busy} !== 4'b0000)
      $display("FAIL mid_reset_outputs: got %b want 0000", {s_ready, s_en, s_done, s_busy});
    else passed++;
    reset = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
    small_load("after_reset", int'(NS), 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
    small_load("start_ignored", 1, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    repeat (3) @(negedge clock);
    total++; if (s_done !== 1'b1) $display("FAIL done_held: got %b want 1", s_done); else passed++;
    for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
    small_load("from_done", int'(NS), 0, 1'b0);
    for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
    small_load("back_to_back", int'(NS), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < int'(NS); i++) sw[i] = WS'($urandom);
      small_load("random", int'($urandom_range(0, NS)), int'($urandom_range(0, 4)), 1'($urandom));
    end
  endtask

  task automatic test_defaults();
    int lat = 0, ens = 0, acc = 0;
    bit done_seen = 0;
    logic [LB-1:0] exp_chain;
    int first_bad = -1;
    for (int i = 0; i < int'(NB); i++) bw[i] = $urandom;
    exp_chain = model_big();
    @(negedge clock); b_start = 1'b1;
    @(negedge clock); b_start = 1'b0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      if (b_ready === 1'b1) begin
        b_valid = 1'b1;
        b_word  = (acc < int'(NB)) ? bw[acc] : $urandom;
        acc++;
      end else begin
        b_valid = 1'b1; b_word = $urandom;
      end
      if (b_en === 1'b1) ens++;
      @(posedge clock);
      @(negedge clock);
      lat++;
      if (b_done === 1'b1) done_seen = 1;
    end
    b_valid = 1'b0;
    for (int i = 0; i < int'(LB); i++)
      if (first_bad < 0 && chain_b[i] !== exp_chain[i]) first_bad = i;
    total++; if (lat != 1654) $display("FAIL big_latency: got %0d want 1654", lat); else passed++;
    total++; if (ens != int'(LB)) $display("FAIL big_enable_count: got %0d want %0d", ens, LB); else passed++;
    total++; if (acc != int'(NB)) $display("FAIL big_words: got %0d want %0d", acc, NB); else passed++;
    total++; if (first_bad >= 0) $display("FAIL big_chain: got differing bit at %0d want none", first_bad); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    s_start = 1'b0; s_valid = 1'b0; s_word = '0;
    b_start = 1'b0; b_valid = 1'b0; b_word = '0;
    test_reset();
    test_basic();
    test_stall();
    test_clear();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_defaults();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
